// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline skid stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_CNT_W  = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// One-cycle pipeline register with optional 2-entry skid; flush kills contents.
// SKID=1 gives a registered in_ready; SKID=0 passes out_ready through to in_ready.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_bubble,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_bubble,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t       state, state_n;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              main_bubble, skid_bubble;
  logic              in_fire, out_fire;
  logic              load_main, load_skid, from_skid;

  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign out_valid  = (state != EMPTY);
  assign out_data   = main_data;
  assign out_bubble = (state == EMPTY) | main_bubble;

  always_comb begin
    state_n   = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    from_skid = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_n   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire && (SKID != 0)) begin
            state_n   = TWO;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_n = EMPTY;
          end
        end
        TWO: begin
          if ((SKID != 0) && out_fire) begin
            state_n   = ONE;
            load_main = 1'b1;
            from_skid = 1'b1;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  // main_data is only rewritten on a load, so it holds its last value while EMPTY
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      main_data   <= '0;
      main_bubble <= 1'b1;
    end else begin
      state <= state_n;
      if (load_main) begin
        main_data   <= from_skid ? skid_data : in_data;
        main_bubble <= from_skid ? skid_bubble : in_bubble;
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic ready_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          skid_data   <= '0;
          skid_bubble <= 1'b1;
          ready_q     <= 1'b0;
        end else begin
          if (load_skid) begin
            skid_data   <= in_data;
            skid_bubble <= in_bubble;
          end
          ready_q <= (state_n != TWO);
        end
      end

      assign in_ready = ready_q;
    end else begin : g_noskid
      logic ready_en;

      // keeps in_ready low until the first edge after reset releases
      always_ff @(posedge clk or posedge reset) begin
        if (reset) ready_en <= 1'b0;
        else       ready_en <= 1'b1;
      end

      assign skid_data   = '0;
      assign skid_bubble = 1'b1;
      assign in_ready    = ready_en & (~out_valid | out_ready);
    end
  endgenerate

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: skid (CNT_W=4) and no-skid instances, directed plus random vs queue model.
module tb_pipe_skid_reg;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance A: SKID=1, CNT_W=4
  logic        a_in_valid, a_in_ready, a_in_bubble, a_out_valid, a_out_ready, a_out_bubble;
  logic        a_flush, a_cnt_clr;
  logic [31:0] a_in_data, a_out_data;
  logic [3:0]  a_stall_cnt;
  // instance B: SKID=0, CNT_W=16
  logic        b_in_valid, b_in_ready, b_in_bubble, b_out_valid, b_out_ready, b_out_bubble;
  logic        b_flush, b_cnt_clr;
  logic [31:0] b_in_data, b_out_data;
  logic [15:0] b_stall_cnt;

  pipe_skid_reg #(.DATA_W(32), .SKID(1), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_bubble(a_in_bubble),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_bubble(a_out_bubble),
    .flush(a_flush), .cnt_clr(a_cnt_clr), .stall_cnt(a_stall_cnt)
  );

  pipe_skid_reg #(.DATA_W(32), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_bubble(b_in_bubble),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_bubble(b_out_bubble),
    .flush(b_flush), .cnt_clr(b_cnt_clr), .stall_cnt(b_stall_cnt)
  );

  // reference model: FIFO of {bubble,data} with a capacity of 2 (A) or 1 (B)
  logic [32:0] qa[$];
  logic [32:0] qb[$];
  bit          ra, rb_en, rb;
  int unsigned sa, sb;
  logic [31:0] la, lb;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_in_valid = 0; a_in_data = '0; a_in_bubble = 0; a_out_ready = 0; a_flush = 0; a_cnt_clr = 0;
    b_in_valid = 0; b_in_data = '0; b_in_bubble = 0; b_out_ready = 0; b_flush = 0; b_cnt_clr = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", a_out_valid); end
    checks++; if (a_out_bubble !== 1'b1) begin errors++; $display("FAIL reset_out_bubble got %b exp 1", a_out_bubble); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_a got %b exp 0", a_in_ready); end
    checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_b got %b exp 0", b_in_ready); end
    checks++; if (a_stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", a_stall_cnt); end
    checks++; if (a_out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data got %h exp 0", a_out_data); end
    reset = 1'b0;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready_a got %b exp 0", a_in_ready); end
    tick();
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL first_edge_in_ready_a got %b exp 1", a_in_ready); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL first_edge_in_ready_b got %b exp 1", b_in_ready); end
  endtask

  task automatic test_basic();
    a_in_valid = 1; a_in_data = 32'hA5A5_A5A5; a_in_bubble = 0; a_out_ready = 1;
    tick();
    a_in_valid = 0;
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", a_out_valid); end
    checks++; if (a_out_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL basic_data got %h exp a5a5a5a5", a_out_data); end
    checks++; if (a_out_bubble !== 1'b0) begin errors++; $display("FAIL basic_bubble got %b exp 0", a_out_bubble); end
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain_valid got %b exp 0", a_out_valid); end
    checks++; if (a_out_bubble !== 1'b1) begin errors++; $display("FAIL basic_empty_bubble got %b exp 1", a_out_bubble); end
    checks++; if (a_out_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL basic_hold_data got %h exp a5a5a5a5", a_out_data); end
  endtask

  task automatic test_skid();
    a_cnt_clr = 1; tick(); a_cnt_clr = 0;
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'h11; a_in_bubble = 0;
    tick();
    a_in_data = 32'h22; a_in_bubble = 1;
    tick();
    a_in_valid = 0;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL skid_full_ready got %b exp 0", a_in_ready); end
    checks++; if (a_out_data !== 32'h11) begin errors++; $display("FAIL skid_head got %h exp 11", a_out_data); end
    tick();
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL skid_hold_ready got %b exp 0", a_in_ready); end
    a_out_ready = 1;
    #1;
    checks++; if (a_out_data !== 32'h11) begin errors++; $display("FAIL skid_first got %h exp 11", a_out_data); end
    tick();
    checks++; if (a_out_data !== 32'h22) begin errors++; $display("FAIL skid_second got %h exp 22", a_out_data); end
    checks++; if (a_out_bubble !== 1'b1) begin errors++; $display("FAIL skid_bubble_carried got %b exp 1", a_out_bubble); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_back got %b exp 1", a_in_ready); end
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL skid_drained got %b exp 0", a_out_valid); end
    checks++; if (a_stall_cnt !== 4'd2) begin errors++; $display("FAIL skid_stall got %0d exp 2", a_stall_cnt); end
  endtask

  task automatic test_flush();
    a_cnt_clr = 1; tick(); a_cnt_clr = 0;
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'h33; a_in_bubble = 0;
    tick();
    a_in_data = 32'h44;
    tick();
    a_in_data = 32'h55; a_flush = 1;
    tick();
    a_flush = 0; a_in_valid = 0;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", a_out_valid); end
    checks++; if (a_out_bubble !== 1'b1) begin errors++; $display("FAIL flush_bubble got %b exp 1", a_out_bubble); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", a_in_ready); end
    checks++; if (a_stall_cnt !== 4'd2) begin errors++; $display("FAIL flush_stall got %0d exp 2", a_stall_cnt); end
    a_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_emit[%0d] got %b exp 0", i, a_out_valid); end
    end
  endtask

  task automatic test_saturate();
    a_cnt_clr = 1; tick(); a_cnt_clr = 0;
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'h66;
    tick();
    a_in_valid = 0;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (a_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_stall got %0d exp 15", a_stall_cnt); end
    a_cnt_clr = 1;
    tick();
    a_cnt_clr = 0;
    checks++; if (a_stall_cnt !== 4'd0) begin errors++; $display("FAIL sat_clr got %0d exp 0", a_stall_cnt); end
    tick();
    checks++; if (a_stall_cnt !== 4'd1) begin errors++; $display("FAIL sat_resume got %0d exp 1", a_stall_cnt); end
    a_flush = 1; tick(); a_flush = 0;
  endtask

  task automatic test_noskid();
    b_out_ready = 0;
    b_in_valid = 1; b_in_data = 32'h100; b_in_bubble = 0;
    tick();
    b_in_data = 32'h101;
    #1;
    checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL noskid_full_ready got %b exp 0", b_in_ready); end
    checks++; if (b_out_data !== 32'h100) begin errors++; $display("FAIL noskid_head got %h exp 100", b_out_data); end
    b_out_ready = 1;
    #1;
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL noskid_comb_ready got %b exp 1", b_in_ready); end
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++; if (b_out_valid !== 1'b1 || b_out_data !== 32'h100 + i)
        begin errors++; $display("FAIL noskid_stream[%0d] got %b/%h exp 1/%h", i, b_out_valid, b_out_data, 32'h100 + i); end
      b_in_data = 32'h100 + i + 1;
    end
    b_in_valid = 0;
    tick();
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL noskid_drain got %b exp 0", b_out_valid); end
  endtask

  task automatic test_async_reset();
    a_out_ready = 0; b_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'h77; b_in_valid = 1; b_in_data = 32'h99;
    tick();
    a_in_data = 32'h88;
    tick();
    a_in_valid = 0; b_in_valid = 0;
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %b exp 1", a_out_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", a_out_valid); end
    checks++; if (a_out_bubble !== 1'b1) begin errors++; $display("FAIL arst_bubble got %b exp 1", a_out_bubble); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL arst_ready got %b exp 0", a_in_ready); end
    checks++; if (a_stall_cnt !== 4'd0) begin errors++; $display("FAIL arst_stall got %0d exp 0", a_stall_cnt); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid_b got %b exp 0", b_out_valid); end
    tick();
    reset = 1'b0;
    a_out_ready = 1; b_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0)
        begin errors++; $display("FAIL arst_no_emit[%0d] got %b/%b exp 0/0", i, a_out_valid, b_out_valid); end
    end
  endtask

  task automatic test_random();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
    qa.delete(); qb.delete();
    ra = 0; rb_en = 0; sa = 0; sb = 0; la = '0; lb = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      a_in_valid  = ($urandom_range(0, 9) < 7);
      a_in_data   = $urandom;
      a_in_bubble = $urandom_range(0, 1);
      a_out_ready = ($urandom_range(0, 9) < 6);
      a_flush     = ($urandom_range(0, 31) == 0);
      a_cnt_clr   = ($urandom_range(0, 31) == 0);
      b_in_valid  = ($urandom_range(0, 9) < 7);
      b_in_data   = $urandom;
      b_in_bubble = $urandom_range(0, 1);
      b_out_ready = ($urandom_range(0, 9) < 6);
      b_flush     = ($urandom_range(0, 31) == 0);
      b_cnt_clr   = ($urandom_range(0, 31) == 0);
      @(negedge clk);
      rb = rb_en && (qb.size() == 0 || b_out_ready);
      checks++; if (a_in_ready !== ra || a_out_valid !== (qa.size() > 0) || a_stall_cnt !== sa[3:0]
                    || a_out_bubble !== ((qa.size() > 0) ? qa[0][32] : 1'b1)
                    || a_out_data !== ((qa.size() > 0) ? qa[0][31:0] : la))
        begin errors++; $display("FAIL rand_a[%0d] got rdy%b vld%b bub%b dat%h cnt%0d exp rdy%b vld%b dat%h cnt%0d",
                                 cyc, a_in_ready, a_out_valid, a_out_bubble, a_out_data, a_stall_cnt,
                                 ra, (qa.size() > 0), (qa.size() > 0) ? qa[0][31:0] : la, sa); end
      checks++; if (b_in_ready !== rb || b_out_valid !== (qb.size() > 0) || b_stall_cnt !== sb[15:0]
                    || b_out_bubble !== ((qb.size() > 0) ? qb[0][32] : 1'b1)
                    || b_out_data !== ((qb.size() > 0) ? qb[0][31:0] : lb))
        begin errors++; $display("FAIL rand_b[%0d] got rdy%b vld%b bub%b dat%h cnt%0d exp rdy%b vld%b dat%h cnt%0d",
                                 cyc, b_in_ready, b_out_valid, b_out_bubble, b_out_data, b_stall_cnt,
                                 rb, (qb.size() > 0), (qb.size() > 0) ? qb[0][31:0] : lb, sb); end
      // advance the model by one edge
      if (a_cnt_clr) sa = 0; else if (qa.size() > 0 && !a_out_ready && sa < 15) sa++;
      if (a_flush) qa.delete();
      else begin
        if (qa.size() > 0 && a_out_ready) void'(qa.pop_front());
        if (a_in_valid && ra) qa.push_back({a_in_bubble, a_in_data});
      end
      ra = (qa.size() < 2);
      if (qa.size() > 0) la = qa[0][31:0];
      if (b_cnt_clr) sb = 0; else if (qb.size() > 0 && !b_out_ready && sb < 65535) sb++;
      if (b_flush) qb.delete();
      else begin
        if (qb.size() > 0 && b_out_ready) void'(qb.pop_front());
        if (b_in_valid && rb) qb.push_back({b_in_bubble, b_in_data});
      end
      rb_en = 1;
      if (qb.size() > 0) lb = qb[0][31:0];
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_skid();
    test_flush();
    test_saturate();
    test_noskid();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
